gate_multi_multi_eval: RTL and testbench
========================================

# gate_multi_multi_eval

Configurable multi-input, multi-output logic gate evaluator. It generalises the fixed-function XOR fan-out gate to selectable functions (AND/OR/NAND/NOR/XOR/XNOR/FAULT), with a registered result, an optional change-pulse output mode, a probabilistic faulty-gate mode driven by an internal LFSR, and a saturating event counter. It sits in the gate layer of the wire simulator, between lamp-state aggregation and the output wire drivers.

## Interface
- INPUT_COUNT, 2, number of lamp inputs (1..32).
- OUTPUT_COUNT, 2, number of replicated output wires (1..32).
- MODE, 4, function: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 FAULT; other values behave as 4.
- OUT_MODE, 0, 0 = level (out follows result), 1 = pulse (one-cycle high on each result change); ignored in FAULT.
- LFSR_SEED, 16'hACE1, LFSR reset value; 0 is replaced by 16'hACE1.
- clk  in  1  single clock, rising edge.
- logic_reset  in  1  asynchronous, active-low reset.
- in  in  INPUT_COUNT  lamp states.
- trig  in  1  trigger strobe, used only in FAULT mode.
- out  out  OUTPUT_COUNT  output wires, all bits always identical.
- changed  out  1  one-cycle strobe per output event.
- events  out  16  saturating count of output events.

## Operation
- Evaluation f(in): AND = &in, OR = |in, NAND = ~&in, NOR = ~|in, XOR = ^in (odd parity), XNOR = ~^in.
- result_q register: loads f(in) every cycle (modes 0-5).
- Level mode: out = {OUTPUT_COUNT{result_q}}. changed pulses in the cycle after result_q changes value.
- Pulse mode: out and changed are both high for exactly one cycle when f(in) != result_q. They register in the same edge that updates result_q. Otherwise they are 0.
- Event: any cycle in which changed = 1. events increments by 1 per event and saturates at 16'hFFFF (no wrap).
- FAULT mode:
  - k = popcount(in), 0..INPUT_COUNT.
  - On a cycle with trig = 1: pass = ((lfsr * INPUT_COUNT) >> 16) < k, using the pre-advance lfsr. The LFSR advances one step on that edge.
  - If pass, out = all ones and changed = 1 for the next cycle only. Otherwise out = 0.
  - k = 0 never passes. k = INPUT_COUNT always passes.
  - trig held high is evaluated independently on every cycle; back-to-back passes give out high for consecutive cycles.
  - result_q is unused and held at 0.
- LFSR: 16-bit Galois. lfsr <= (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 0). It advances only on trig in FAULT mode and never reaches 0.

## Timing
- Reset (logic_reset = 0, asynchronous):
  - result_q = f(all zeros): 0 for AND/OR/XOR/FAULT, 1 for NAND/NOR/XNOR.
  - out = level mode ? {OUTPUT_COUNT{result_q reset}} : 0.
  - changed = 0, events = 0, lfsr = seed.
- No spurious event on reset release with in = 0.
- Latency: in → out/changed is 1 clock in all modes. Level-mode changed lags out by 1 further clock.
- A change in in lasting one cycle produces two events (rise then fall) in modes 0-5.
- Reset asserted mid-pulse: out and changed drop immediately, without waiting for a clock.
- The events counter and the output update on the same edge. At saturation, further events still drive out and changed.

## Test plan
- MODE=4, OUT_MODE=0, INPUT_COUNT=3: in 000→001→011→111 on successive cycles → out 0,1,0,1 (each one cycle later); changed pulses 3 times; events = 3.
- MODE=2, OUT_MODE=1: reset with in=00 → out=0, no pulse after release. Then set in=11 → one-cycle out=11 and changed=1. Then in=10 → another one-cycle pulse. events = 2.
- MODE=6, INPUT_COUNT=4: in=0000 with trig for 100 cycles → out never high. in=1111 with trig for 100 cycles → out high 100 cycles, events = 100.
- MODE=6, INPUT_COUNT=4, in=0011, seed 16'hACE1, trig 1000 cycles → pass count matches the reference LFSR model exactly (≈500).
- Saturation: preload by 65 540 events with MODE=1 toggling in → events holds 16'hFFFF and pulses continue.
- Assert logic_reset asynchronously mid-pulse → out, changed, and events are 0 before the next clk edge. The LFSR reloads the seed.

Source files
------------

// File: rtl/gate_multi_multi_eval.sv
// rtl/gate_multi_multi_eval.sv - configurable multi-input gate with level/pulse/faulty modes and event counter
module gate_multi_multi_eval #(
    parameter int          INPUT_COUNT  = 2,
    parameter int          OUTPUT_COUNT = 2,
    parameter int          MODE         = 4,
    parameter int          OUT_MODE     = 0,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                    clk,
    input  logic                    logic_reset,
    input  logic [INPUT_COUNT-1:0]  in,
    input  logic                    trig,
    output logic [OUTPUT_COUNT-1:0] out,
    output logic                    changed,
    output logic [15:0]             events
);

    localparam int          EFF_MODE   = (MODE >= 0 && MODE <= 6) ? MODE : 4;
    localparam bit          IS_FAULT   = (EFF_MODE == 6);
    localparam bit          PULSE_OUT  = IS_FAULT || (OUT_MODE == 1);
    localparam logic [15:0] SEED       = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;
    localparam logic        RESULT_RST = (EFF_MODE == 2) || (EFF_MODE == 3) || (EFF_MODE == 5);

    logic        result_q, result_d;
    logic        prev_q;
    logic        pulse_q, pulse_d;
    logic        changed_q, changed_d;
    logic [15:0] events_q, events_d;
    logic [15:0] lfsr_q, lfsr_d, lfsr_next;
    logic        f_in;
    logic [5:0]  k;
    logic [21:0] scaled;
    logic        pass;

    always_comb begin
        case (EFF_MODE)
            0:       f_in = &in;
            1:       f_in = |in;
            2:       f_in = ~&in;
            3:       f_in = ~|in;
            5:       f_in = ~^in;
            default: f_in = ^in;
        endcase
    end

    always_comb begin
        k = 6'd0;
        for (int i = 0; i < INPUT_COUNT; i++) begin
            k = k + 6'(in[i]);
        end
    end

    // floor(lfsr*N / 2^16) < k is equivalent to lfsr*N < k*2^16
    assign scaled    = 22'(lfsr_q) * 22'(INPUT_COUNT);
    assign pass      = scaled < {k, 16'h0000};
    assign lfsr_next = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

    always_comb begin
        result_d = IS_FAULT ? 1'b0 : f_in;
        pulse_d  = 1'b0;
        if (IS_FAULT) begin
            pulse_d = trig && pass;
        end else if (PULSE_OUT) begin
            pulse_d = (f_in != result_q);
        end
        // level mode reports a change one clock after it shows on out
        changed_d = PULSE_OUT ? pulse_d : (result_q != prev_q);
        events_d  = (changed_d && events_q != 16'hFFFF) ? events_q + 16'd1 : events_q;
        lfsr_d    = (IS_FAULT && trig) ? lfsr_next : lfsr_q;
    end

    always_ff @(posedge clk or negedge logic_reset) begin
        if (!logic_reset) begin
            result_q  <= IS_FAULT ? 1'b0 : RESULT_RST;
            prev_q    <= IS_FAULT ? 1'b0 : RESULT_RST;
            pulse_q   <= 1'b0;
            changed_q <= 1'b0;
            events_q  <= 16'h0000;
            lfsr_q    <= SEED;
        end else begin
            result_q  <= result_d;
            prev_q    <= result_q;
            pulse_q   <= pulse_d;
            changed_q <= changed_d;
            events_q  <= events_d;
            lfsr_q    <= lfsr_d;
        end
    end

    assign out     = {OUTPUT_COUNT{PULSE_OUT ? pulse_q : result_q}};
    assign changed = changed_q;
    assign events  = events_q;

endmodule

// File: tb/tb_gate_multi_multi_eval.sv
// tb/tb_gate_multi_multi_eval.sv - directed self-checking bench for gate_multi_multi_eval
module tb_gate_multi_multi_eval;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [2:0]  in_x;
    logic [1:0]  in_n, in_o;
    logic [3:0]  in_f;
    logic        trig_f;
    logic [1:0]  out_x, out_n, out_f, out_o;
    logic        chg_x, chg_n, chg_f, chg_o;
    logic [15:0] ev_x, ev_n, ev_f, ev_o;

    int checks = 0;
    int errors = 0;

    gate_multi_multi_eval #(.INPUT_COUNT(3), .OUTPUT_COUNT(2), .MODE(4), .OUT_MODE(0)) u_xor (
        .clk(clk), .logic_reset(rst_n), .in(in_x), .trig(1'b0),
        .out(out_x), .changed(chg_x), .events(ev_x));

    gate_multi_multi_eval #(.INPUT_COUNT(2), .OUTPUT_COUNT(2), .MODE(2), .OUT_MODE(1)) u_nand (
        .clk(clk), .logic_reset(rst_n), .in(in_n), .trig(1'b0),
        .out(out_n), .changed(chg_n), .events(ev_n));

    gate_multi_multi_eval #(.INPUT_COUNT(4), .OUTPUT_COUNT(2), .MODE(6), .OUT_MODE(0),
                            .LFSR_SEED(16'hACE1)) u_fault (
        .clk(clk), .logic_reset(rst_n), .in(in_f), .trig(trig_f),
        .out(out_f), .changed(chg_f), .events(ev_f));

    gate_multi_multi_eval #(.INPUT_COUNT(2), .OUTPUT_COUNT(2), .MODE(1), .OUT_MODE(1)) u_or (
        .clk(clk), .logic_reset(rst_n), .in(in_o), .trig(1'b0),
        .out(out_o), .changed(chg_o), .events(ev_o));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    int          hi;
    int          passes;
    logic [15:0] lfsr_m;
    logic [21:0] prod_m;
    logic        exp_pass;

    initial begin
        rst_n = 1'b0; in_x = '0; in_n = '0; in_o = '0; in_f = '0; trig_f = 1'b0;
        tick; tick;
        check("rst_xor_out", out_x, 32'h0);
        check("rst_xor_chg", chg_x, 32'h0);
        check("rst_xor_ev", ev_x, 32'h0);
        check("rst_nand_out", out_n, 32'h0);
        check("rst_fault_out", out_f, 32'h0);

        rst_n = 1'b1;
        tick; tick;
        check("rel_nand_out", out_n, 32'h0);
        check("rel_nand_chg", chg_n, 32'h0);
        check("rel_xor_ev", ev_x, 32'h0);

        // XOR level mode: 000 -> 001 -> 011 -> 111
        in_x = 3'b001; tick;
        check("xor1_out", out_x, 32'h3);
        check("xor1_chg", chg_x, 32'h0);
        in_x = 3'b011; tick;
        check("xor2_out", out_x, 32'h0);
        check("xor2_chg", chg_x, 32'h1);
        in_x = 3'b111; tick;
        check("xor3_out", out_x, 32'h3);
        check("xor3_chg", chg_x, 32'h1);
        tick;
        check("xor4_chg", chg_x, 32'h1);
        check("xor4_ev", ev_x, 32'd3);
        tick;
        check("xor5_chg", chg_x, 32'h0);
        check("xor5_ev", ev_x, 32'd3);

        // one-cycle glitch gives two events
        in_x = 3'b110; tick;
        check("glitch_out", out_x, 32'h0);
        in_x = 3'b111; tick; tick; tick;
        check("glitch_ev", ev_x, 32'd5);

        // NAND pulse mode
        in_n = 2'b11; tick;
        check("nand1_out", out_n, 32'h3);
        check("nand1_chg", chg_n, 32'h1);
        tick;
        check("nand1b_out", out_n, 32'h0);
        check("nand1b_chg", chg_n, 32'h0);
        in_n = 2'b10; tick;
        check("nand2_out", out_n, 32'h3);
        tick;
        check("nand2b_out", out_n, 32'h0);
        check("nand_ev", ev_n, 32'd2);

        // FAULT: k=0 never passes, k=N always passes
        in_f = 4'b0000; trig_f = 1'b1; hi = 0;
        for (int i = 0; i < 100; i++) begin
            tick;
            if (out_f != 2'b00) hi++;
        end
        check("fault_k0_hi", hi, 32'd0);
        in_f = 4'b1111; hi = 0;
        for (int i = 0; i < 100; i++) begin
            tick;
            if (out_f == 2'b11 && chg_f) hi++;
        end
        check("fault_kn_hi", hi, 32'd100);
        trig_f = 1'b0; tick;
        check("fault_notrig_out", out_f, 32'h0);
        check("fault_kn_ev", ev_f, 32'd100);

        // FAULT k=2 against reference LFSR; reset must reload the seed
        rst_n = 1'b0; tick;
        rst_n = 1'b1; in_f = 4'b0011; trig_f = 1'b1;
        lfsr_m = 16'hACE1; passes = 0;
        for (int i = 0; i < 1000; i++) begin
            prod_m   = 22'(lfsr_m) * 22'd4;
            exp_pass = (prod_m >> 16) < 22'd2;
            lfsr_m   = (lfsr_m >> 1) ^ (lfsr_m[0] ? 16'hB400 : 16'h0000);
            if (exp_pass) passes++;
            tick;
            check("fault_k2_out", out_f, exp_pass ? 32'h3 : 32'h0);
        end
        trig_f = 1'b0; tick;
        check("fault_k2_ev", ev_f, 32'(passes));

        // saturation with OR pulse mode
        rst_n = 1'b0; tick;
        rst_n = 1'b1; in_o = 2'b00;
        for (int i = 0; i < 65540; i++) begin
            in_o = i[0] ? 2'b00 : 2'b01;
            tick;
        end
        check("sat_ev", ev_o, 32'hFFFF);
        check("sat_out", out_o, 32'h3);
        in_o = 2'b01; tick;
        check("sat2_out", out_o, 32'h3);
        check("sat2_chg", chg_o, 32'h1);
        check("sat2_ev", ev_o, 32'hFFFF);

        // asynchronous reset mid-pulse
        rst_n = 1'b0; #2;
        check("async_out", out_o, 32'h0);
        check("async_chg", chg_o, 32'h0);
        check("async_ev", ev_o, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
